// File: rtl/prng_range_fifo_if.sv
// Random-word stream from the xoshiro128++ generator to its consumers.
// The generator drives the word and its valid flag; the consumer pulses src_next to advance it.
interface prng_range_fifo_if;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_next;

  modport master (output src_data, output src_valid, input src_next);
  modport slave  (input src_data, input src_valid, output src_next);
endinterface

// File: rtl/prng_range_fifo.sv
// Reduces generator words to uniform integers in [0, N) by mask-and-reject sampling.
// Accepted values are buffered in a prefetch FIFO so the bus can read them back-to-back.
module prng_range_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  prng_range_fifo_if.slave         src,
  input  logic                     limit_we,
  input  logic [31:0]              limit_in,
  input  logic                     pop,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         reject_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {S_FILL, S_WAIT} state_e;

  // Smallest all-ones mask covering N-1; N==0 selects the full 32-bit range.
  function automatic logic [31:0] mask_of(input logic [31:0] n);
    logic [31:0] m;
    if (n == 32'd0) return '1;
    m = n - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       limit_q;
  logic [31:0]       mask_q;
  logic [31:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [CNT_W-1:0]  rej_q;

  logic [31:0]       cand_c;
  logic              accept_c;
  logic              full_c;
  logic              next_c;
  logic              push_c;
  logic              rej_c;
  logic              pop_c;

  assign cand_c   = src.src_data & mask_q;
  assign accept_c = (limit_q == 32'd0) || (cand_c < limit_q);
  assign full_c   = (level_q == LW'(DEPTH));
  // A limit load owns the cycle, so a simultaneous pop is dropped.
  assign pop_c    = pop && (level_q != '0) && !limit_we;

  // Next-state and per-cycle actions of the draw sequencer.
  always_comb begin
    state_d = state_q;
    next_c  = 1'b0;
    push_c  = 1'b0;
    rej_c   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (!full_c && src.src_valid) begin
          next_c  = 1'b1;
          state_d = S_WAIT;
          if (accept_c) push_c = 1'b1;
          else          rej_c  = 1'b1;
        end
      end
      S_WAIT:  state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
    // WAIT after a load lets the new mask settle before the next evaluation.
    if (limit_we) begin
      state_d = S_WAIT;
      next_c  = 1'b0;
      push_c  = 1'b0;
      rej_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      limit_q  <= 32'd0;
      mask_q   <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rej_q    <= '0;
    end else if (limit_we) begin
      state_q  <= state_d;
      limit_q  <= limit_in;
      mask_q   <= mask_of(limit_in);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rej_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_c) - LW'(pop_c);
      if (rej_c && (rej_q != '1)) rej_q <= rej_q + CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) mem_q[wr_ptr_q] <= cand_c;
  end

  assign src.src_next = rst_n & next_c;
  assign out_valid    = (level_q != '0);
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign level        = level_q;
  assign reject_cnt   = rej_q;

endmodule

// File: tb/tb_prng_range_fifo.sv
// Scoreboard bench for prng_range_fifo: a reference model predicts every FIFO entry,
// the reject count and the src_next cadence; directed checks cover the range-reduction cases.
module tb_prng_range_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic        clk;
  logic        rst_n;
  logic        limit_we;
  logic [31:0] limit_in;
  logic        pop;
  logic [31:0] out_data;
  logic        out_valid;
  logic [2:0]  level;
  logic [15:0] reject_cnt;

  prng_range_fifo_if src_if ();

  prng_range_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src        (src_if),
    .limit_we   (limit_we),
    .limit_in   (limit_in),
    .pop        (pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .level      (level),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mask(input logic [31:0] n);
    logic [31:0] m;
    logic [63:0] one;
    int          hb;
    if (n == 32'd0) return 32'hFFFF_FFFF;
    m  = n - 32'd1;
    hb = -1;
    for (int i = 0; i < 32; i++) if (m[i]) hb = i;
    one = 64'd1;
    return 32'((one << (hb + 1)) - 64'd1);
  endfunction

  // Reference model state
  logic [31:0] exp_q[$];
  logic [15:0] rej_m    = '0;
  logic [31:0] limit_m  = '0;
  logic [31:0] mask_m   = 32'hFFFF_FFFF;
  bit          wait_m   = 1'b0;
  bit          prev_nx  = 1'b0;
  bit          mon_on   = 1'b0;

  // Generator model state
  logic [31:0] src_q[$];
  bit          gen_hold = 1'b0;

  always @(negedge clk) begin
    bit          en;
    logic [31:0] c;
    if (mon_on) begin
      en = rst_n && !limit_we && !wait_m && (exp_q.size() < DEPTH) && src_if.src_valid;
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
      chk("reject_cnt", 32'(reject_cnt), 32'(rej_m));
      chk("src_next", 32'(src_if.src_next), 32'(en));
      chk("next_b2b", 32'(prev_nx && src_if.src_next), 32'd0);
      prev_nx = src_if.src_next;
      if (!rst_n) begin
        exp_q.delete();
        rej_m   = '0;
        limit_m = '0;
        mask_m  = 32'hFFFF_FFFF;
        wait_m  = 1'b0;
      end else if (limit_we) begin
        exp_q.delete();
        rej_m   = '0;
        limit_m = limit_in;
        mask_m  = ref_mask(limit_in);
        wait_m  = 1'b1;
      end else begin
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (en) begin
          c = src_if.src_data & mask_m;
          if (limit_m == 32'd0 || c < limit_m) exp_q.push_back(c);
          else if (rej_m != 16'hFFFF) rej_m = rej_m + 16'd1;
          wait_m = 1'b1;
        end else if (wait_m) begin
          wait_m = 1'b0;
        end
      end
    end
  end

  // One clock: sample src_next mid-cycle, then advance the generator after the edge.
  task automatic cyc(output bit nx);
    @(negedge clk);
    nx = src_if.src_next;
    @(posedge clk);
    #1;
    if (nx) begin
      if (src_q.size() != 0) src_if.src_data = src_q.pop_front();
      else if (!gen_hold)    src_if.src_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    bit nx;
    for (int i = 0; i < n; i++) cyc(nx);
  endtask

  task automatic load_limit(input logic [31:0] n, input logic [31:0] first);
    limit_in          = n;
    limit_we          = 1'b1;
    src_if.src_data   = first;
    src_if.src_valid  = 1'b1;
    run(1);
    limit_we = 1'b0;
  endtask

  initial begin
    bit nx;
    rst_n            = 1'b0;
    limit_we         = 1'b0;
    limit_in         = '0;
    pop              = 1'b0;
    src_if.src_data  = '0;
    src_if.src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    run(1);

    // Full-range fill from a held word
    src_if.src_data  = 32'hDEAD_BEEF;
    src_if.src_valid = 1'b1;
    gen_hold         = 1'b1;
    rst_n            = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(nx);
      chk("fill_next_cadence", 32'(nx), 32'((i < 8) && (i % 2 == 0)));
    end
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_head", out_data, 32'hDEAD_BEEF);
    chk("fill_rej", 32'(reject_cnt), 32'd0);

    // N=5: candidates 7,5,3,5,2 -> accept 3 and 2
    gen_hold = 1'b0;
    src_q    = '{32'd5, 32'd3, 32'd13, 32'h12};
    load_limit(32'd5, 32'd7);
    run(14);
    chk("n5_rej", 32'(reject_cnt), 32'd3);
    chk("n5_level", 32'(level), 32'd2);
    chk("n5_head0", out_data, 32'd3);
    pop = 1'b1; run(1); pop = 1'b0;
    chk("n5_head1", out_data, 32'd2);
    pop = 1'b1; run(1); pop = 1'b0;
    chk("n5_drained", 32'(level), 32'd0);

    // N=1: everything maps to 0
    src_q = '{$urandom(), $urandom()};
    load_limit(32'd1, $urandom() | 32'h8000_0001);
    run(10);
    chk("n1_level", 32'(level), 32'd3);
    chk("n1_head", out_data, 32'd0);
    chk("n1_rej", 32'(reject_cnt), 32'd0);
    pop = 1'b1; run(4); pop = 1'b0;

    // N=2^31: top bit masked off, 7FFFFFFF accepted
    load_limit(32'h8000_0000, 32'hFFFF_FFFF);
    run(5);
    chk("n2p31_head", out_data, 32'h7FFF_FFFF);
    chk("n2p31_level", 32'(level), 32'd1);
    chk("n2p31_rej", 32'(reject_cnt), 32'd0);
    pop = 1'b1; run(1); pop = 1'b0;

    // Full FIFO, single pop, refill and ordered drain
    for (int i = 0; i < 11; i++) src_q.push_back($urandom());
    load_limit(32'd0, $urandom());
    run(12);
    chk("full_level", 32'(level), 32'd4);
    pop = 1'b1; run(1); pop = 1'b0;
    chk("pop_level", 32'(level), 32'd3);
    run(2);
    chk("refill_level", 32'(level), 32'd4);
    pop = 1'b1; run(30); pop = 1'b0;
    chk("drain_level", 32'(level), 32'd0);
    pop = 1'b1; run(2); pop = 1'b0;
    chk("pop_empty_level", 32'(level), 32'd0);
    chk("pop_empty_data", out_data, 32'd0);

    // Limit load with pop on a full FIFO
    gen_hold = 1'b1;
    load_limit(32'd0, 32'h0BAD_F00D);
    run(10);
    chk("pre_load_level", 32'(level), 32'd4);
    gen_hold = 1'b0;
    src_q    = '{32'h23};
    pop      = 1'b1;
    load_limit(32'd10, 32'h1F);
    pop      = 1'b0;
    chk("load_flush_level", 32'(level), 32'd0);
    chk("load_flush_rej", 32'(reject_cnt), 32'd0);
    chk("load_wait_next", 32'(src_if.src_next), 32'd0);
    run(6);
    chk("n10_rej", 32'(reject_cnt), 32'd1);
    chk("n10_level", 32'(level), 32'd1);
    chk("n10_head", out_data, 32'd3);

    // Reset mid-fill
    gen_hold         = 1'b1;
    src_if.src_data  = 32'hFF;
    src_if.src_valid = 1'b1;
    run(4);
    rst_n = 1'b0;
    run(1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_rej", 32'(reject_cnt), 32'd0);
    chk("rst_next", 32'(src_if.src_next), 32'd0);
    rst_n = 1'b1;
    run(4);
    chk("post_rst_head", out_data, 32'hFF);
    chk("post_rst_level", 32'(level), 32'd2);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prng_range_fifo.md
Name: prng_range_fifo

Overview:
- Downstream consumer of the xoshiro128++ random-word stream inside the PRNG peripheral.
- Draws 32-bit words from the generator and reduces each to a uniform integer in [0, N) by mask-and-reject sampling.
- Buffers accepted values in a small prefetch FIFO so the TinyQV bus can read bounded random numbers back-to-back without stalling.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- src_data  input  32  current generator output word.
- src_valid  input  1  src_data holds a usable word.
- src_next  output  1  one-cycle pulse that advances the generator.
- limit_we  input  1  load a new range limit.
- limit_in  input  32  range limit N; 0 means full 32-bit range.
- pop  input  1  consume the FIFO head.
- out_data  output  32  FIFO head value; 0 when the FIFO is empty.
- out_valid  output  1  FIFO is non-empty.
- level  output  $clog2(DEPTH)+1  number of occupied entries.
- reject_cnt  output  CNT_W  number of rejected candidates since reset or the last limit load; saturates at all-ones.

Behaviour:
- Reset:
  - limit=0 and mask=32'hFFFFFFFF.
  - FIFO empty, level=0, out_valid=0, out_data=0.
  - src_next=0, reject_cnt=0, FSM in S_FILL.
- Mask rule:
  - N=0: mask=FFFFFFFF and every candidate is accepted.
  - N=1: mask=0.
  - N>=2: mask is all ones from bit 0 through the highest set bit of (N-1).
  - mask is registered and updated in the cycle after limit_we.
- Candidate: cand = src_data & mask. Accept iff N==0 or cand < N (unsigned compare).
- FSM has two states:
  - S_FILL, when level<DEPTH and src_valid=1:
    - Evaluate cand.
    - If accepted, push cand. Otherwise increment reject_cnt (saturating).
    - Drive src_next=1 for this one cycle, then go to S_WAIT.
    - If full or !src_valid, stay in S_FILL with src_next=0.
  - S_WAIT: src_next=0 for one cycle so the generator can update, then go to S_FILL.
  - Throughput: at most one candidate per 2 cycles. src_next is never high on two consecutive cycles.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - Push appears at out_data/out_valid the cycle after the push (first-word latency from empty is 1 cycle).
  - Pop when out_valid=1 advances the head at the next edge. Pop when empty is ignored; level stays 0.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Full is evaluated on the registered level, so no push happens while level==DEPTH, even if pop is asserted in that cycle.
  - The entry freed by a pop is fillable from the next S_FILL cycle.
- Limit load (limit_we=1):
  - At the next edge: limit<=limit_in, FIFO flushed (level=0, pointers=0), reject_cnt=0, FSM forced to S_WAIT so the new mask is valid before the next evaluation.
  - No push happens in the limit_we cycle.
  - limit_we together with pop: the load wins and the pop is ignored.
- src_next is suppressed in the limit_we cycle.
- Reset mid-operation returns every register to its reset value at the next edge, regardless of state.

Test Plan:
- Reset, then src_valid=1 with src_data=32'hDEADBEEF held -> src_next pulses at cycles 0,2,4,6; FIFO fills to level=4 with DEADBEEF×4, then src_next stays 0; reject_cnt=0.
- limit_in=5, source sequence 7,5,3,13,0x12 -> masked candidates 7,5,3,5,2; accepted 3 then 2; reject_cnt=3; out_data reads 3 then 2.
- limit_in=1, arbitrary source words -> every output is 0 and reject_cnt stays 0.
- limit_in=32'h80000000, source word 32'hFFFFFFFF -> out_data=32'h7FFFFFFF and it is accepted.
- FIFO full (level=4), pop asserted for 1 cycle while source is valid -> level=3 next cycle, refilled to 4 within 2 cycles; popped values come out in push order. Pop when empty -> level stays 0 and out_data=0.
- Full FIFO with pop and limit_we(limit_in=10) in the same cycle -> level=0, reject_cnt=0, next cycle is S_WAIT with src_next=0, first evaluation uses mask=4'hF; rst_n low mid-fill -> all outputs return to reset values.
